imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined RISC-V immediate encoder. It packs a signed immediate plus register and funct3 fields into a 32-bit I-ALU, I-load, S or B instruction word, and performs the inverse of the core's immediate extraction. It sits in the test/boot path ahead of instruction memory, with valid/ready on both sides, a two-stage pipeline and an out-of-range detector.

## Interface
Parameters:
- CNT_W, 16, width of accepted-instruction counter.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
- fmt_i  input  2  format: 00 I-ALU (opcode 0010011), 01 I-load (0000011), 10 S (0100011), 11 B (1100011).
- imm_i  input  32  signed immediate (byte offset for B).
- rd_i  input  5  destination register; ignored for S/B.
- rs1_i  input  5  source 1.
- rs2_i  input  5  source 2; ignored for I formats.
- funct3_i  input  3  funct3 field.
- out_valid_o  output  1  instruction valid.
- out_ready_i  input  1  downstream accept.
- ins_o  output  32  encoded instruction.
- err_o  output  1  immediate was out of range; qualified by out_valid_o.
- count_o  output  CNT_W  number of requests accepted, wraps.
- err_count_o  output  ERR_W  number of errored outputs delivered, saturates at all-ones.

## Operation
- Stage 1 (S1) registers the request fields and computes the range flag.
- Stage 2 (S2) registers the packed word and the error flag. It drives ins_o and err_o.
- Packing, with opcode from fmt_i:
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- Range rule for I and S: imm_i[31:11] must be all-equal, i.e. -2048..2047.
- Range rule for B: imm_i[31:12] must be all-equal and imm_i[0]==0, i.e. -4096..4094 and even.
- Errored request:
  - ins_o = 32'h00000013 (addi x0,x0,0) and err_o=1.
  - Still consumes one pipeline slot and is counted in count_o.
- Flow control:
  - s2_adv = !s2_valid || out_ready_i.
  - s1_adv = s1_valid && s2_adv.
  - in_ready_o = !s1_valid || s2_adv (combinational, no in_valid_i dependency).
- count_o increments on each input handshake and wraps modulo 2^CNT_W.
- err_count_o increments on each output handshake with err_o=1 and holds at max.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid_o=0, ins_o=0, err_o=0.
  - count_o=0, err_count_o=0.
  - s1_valid=0, so in_ready_o=1.
- Latency: handshake at edge N gives out_valid_o=1 after edge N+1 (two registers). Min latency from in_valid_i to out_valid_o is 2 cycles.
- Throughput: 1 instruction/cycle while out_ready_i=1.
- Backpressure: with out_ready_i=0 and both stages full, in_ready_o=0. ins_o and err_o stay stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous S2 drain and S1 advance in one edge: no bubble, no loss.
- Reset mid-operation drops in-flight entries. Counters clear; no partial output.

## Configuration
- IMM_ENC_RANGE_CHECK_EN defined:
  - Range check, NOP substitution, err_o and err_count_o active as above.
- Not defined:
  - No range logic.
  - Immediate bits are truncated into fields as-is; B ignores imm_i[0].
  - err_o tied 0, err_count_o tied 0.

## Test plan
- Reset then idle -> in_ready_o=1, out_valid_o=0, count_o=0.
- I-ALU, imm=-1, rd=5, rs1=6, f3=0 -> ins_o=32'hFFF30293, err_o=0, 2 cycles after accept.
- S, imm=8, rs1=2, rs2=10, f3=2 -> 32'h00A12423.
- B, imm=-4, rs1=1, rs2=2, f3=0 -> 32'hFE208EE3.
- B, imm=3 (check on) -> ins_o=32'h00000013, err_o=1, err_count_o=1.
- Back-to-back stream of 4 requests with out_ready_i low for 3 cycles -> in_ready_o=0 after 2 accepts, then all 4 outputs in order, count_o=4.
- Async reset asserted with both stages full -> all outputs at reset values immediately.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder for the I-ALU,
// I-load, S and B formats, with valid/ready on both sides.
// Optional feature macro: IMM_ENC_RANGE_CHECK_EN. When it is defined,
// out-of-range immediates are replaced by a NOP and flagged on err_o and
// counted in err_count_o. When it is undefined, immediates are truncated
// into their fields and err_o/err_count_o read as zero.
module imm_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       fmt_i,
    input  logic [31:0]      imm_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      ins_o,
    output logic             err_o,
    output logic [CNT_W-1:0] count_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam logic [1:0]  FMT_I_ALU = 2'b00;
    localparam logic [1:0]  FMT_I_LD  = 2'b01;
    localparam logic [1:0]  FMT_S     = 2'b10;
    localparam logic [1:0]  FMT_B     = 2'b11;
    localparam logic [31:0] NOP_INS   = 32'h0000_0013;

    // Stage 1 state: request fields; only imm[12:0] ever reaches a field.
    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_fmt_q,   s1_fmt_d;
    logic [12:0] s1_imm_q,   s1_imm_d;
    logic [4:0]  s1_rd_q,    s1_rd_d;
    logic [4:0]  s1_rs1_q,   s1_rs1_d;
    logic [4:0]  s1_rs2_q,   s1_rs2_d;
    logic [2:0]  s1_f3_q,    s1_f3_d;

    // Stage 2 state: packed word driven straight onto ins_o.
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_ins_q,   s2_ins_d;

    logic [CNT_W-1:0] count_q, count_d;

    // Handshake and packing intermediates.
    logic        s2_adv_s;
    logic        s1_adv_s;
    logic        in_fire_s;
    logic        out_fire_s;
    logic [6:0]  opcode_s;
    logic [31:0] pack_s;

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic             range_err_s;
    logic             s1_err_q, s1_err_d;
    logic             s2_err_q, s2_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`else
    // Upper immediate bits have no destination when truncating.
    logic             unused_imm_s;
    assign unused_imm_s = ^imm_i[31:13];
`endif

    // Pipeline advance conditions; in_ready_o never looks at in_valid_i.
    always_comb begin
        s2_adv_s   = !s2_valid_q || out_ready_i;
        s1_adv_s   = s1_valid_q && s2_adv_s;
        in_ready_o = !s1_valid_q || s2_adv_s;
        in_fire_s  = in_valid_i && in_ready_o;
        out_fire_s = s2_valid_q && out_ready_i;
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    // Range detector: I/S need a 12-bit signed value, B a 13-bit even one.
    always_comb begin
        range_err_s = 1'b0;
        case (fmt_i)
            FMT_B: begin
                range_err_s = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
            end
            FMT_I_ALU, FMT_I_LD, FMT_S: begin
                range_err_s = !((&imm_i[31:11]) || !(|imm_i[31:11]));
            end
            default: begin
                range_err_s = 1'b0;
            end
        endcase
    end
`endif

    // Stage 1 next state: load on accept, empty when handed to stage 2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_fmt_d   = s1_fmt_q;
        s1_imm_d   = s1_imm_q;
        s1_rd_d    = s1_rd_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_f3_d    = s1_f3_q;
`ifdef IMM_ENC_RANGE_CHECK_EN
        s1_err_d   = s1_err_q;
`endif
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_fmt_d   = fmt_i;
            s1_imm_d   = imm_i[12:0];
            s1_rd_d    = rd_i;
            s1_rs1_d   = rs1_i;
            s1_rs2_d   = rs2_i;
            s1_f3_d    = funct3_i;
`ifdef IMM_ENC_RANGE_CHECK_EN
            s1_err_d   = range_err_s;
`endif
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Opcode select and field packing from the stage-1 registers.
    always_comb begin
        opcode_s = 7'b0010011;
        pack_s   = 32'h0000_0000;
        case (s1_fmt_q)
            FMT_I_ALU: opcode_s = 7'b0010011;
            FMT_I_LD:  opcode_s = 7'b0000011;
            FMT_S:     opcode_s = 7'b0100011;
            FMT_B:     opcode_s = 7'b1100011;
            default:   opcode_s = 7'b0010011;
        endcase
        case (s1_fmt_q)
            FMT_S: begin
                pack_s = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:0], opcode_s};
            end
            FMT_B: begin
                pack_s = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                          s1_f3_q, s1_imm_q[4:1], s1_imm_q[11], opcode_s};
            end
            default: begin
                pack_s = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, opcode_s};
            end
        endcase
    end

    // Stage 2 next state: take stage 1 when it advances, else drain or hold.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_ins_d   = s2_ins_q;
`ifdef IMM_ENC_RANGE_CHECK_EN
        s2_err_d   = s2_err_q;
`endif
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
`ifdef IMM_ENC_RANGE_CHECK_EN
            s2_ins_d   = s1_err_q ? NOP_INS : pack_s;
            s2_err_d   = s1_err_q;
`else
            s2_ins_d   = pack_s;
`endif
        end else if (out_fire_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Accepted-request counter, wraps naturally.
    always_comb begin
        if (in_fire_s) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    // Delivered-error counter, saturating at all-ones.
    always_comb begin
        if (out_fire_s && s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end
`endif

    // State registers; reset drops in-flight entries and clears counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= 2'b00;
            s1_imm_q   <= 13'h0000;
            s1_rd_q    <= 5'd0;
            s1_rs1_q   <= 5'd0;
            s1_rs2_q   <= 5'd0;
            s1_f3_q    <= 3'd0;
            s2_valid_q <= 1'b0;
            s2_ins_q   <= 32'h0000_0000;
            count_q    <= {CNT_W{1'b0}};
`ifdef IMM_ENC_RANGE_CHECK_EN
            s1_err_q   <= 1'b0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= {ERR_W{1'b0}};
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_imm_q   <= s1_imm_d;
            s1_rd_q    <= s1_rd_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_f3_q    <= s1_f3_d;
            s2_valid_q <= s2_valid_d;
            s2_ins_q   <= s2_ins_d;
            count_q    <= count_d;
`ifdef IMM_ENC_RANGE_CHECK_EN
            s1_err_q   <= s1_err_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign out_valid_o = s2_valid_q;
    assign ins_o       = s2_ins_q;
    assign count_o     = count_q;
`ifdef IMM_ENC_RANGE_CHECK_EN
    assign err_o       = s2_err_q;
    assign err_count_o = err_cnt_q;
`else
    assign err_o       = 1'b0;
    assign err_count_o = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: table of directed encodings plus
// hand-written backpressure and mid-operation reset sequences.
// Expectations follow IMM_ENC_RANGE_CHECK_EN when it is defined.
module tb_imm_encoder;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;
    localparam int NV    = 10;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       fmt_i;
    logic [31:0]      imm_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      ins_o;
    logic             err_o;
    logic [CNT_W-1:0] count_o;
    logic [ERR_W-1:0] err_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    imm_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fmt_i(fmt_i), .imm_i(imm_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct3_i(funct3_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .ins_o(ins_o), .err_o(err_o),
        .count_o(count_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] ins_chk;   // expected word with range checking
        logic        err_chk;   // expected err_o with range checking
        logic [31:0] ins_raw;   // expected word when truncating
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_req(input logic v, input logic [1:0] f, input logic [31:0] im,
                           input logic [4:0] rd, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [2:0] f3);
        in_valid_i = v; fmt_i = f; imm_i = im; rd_i = rd;
        rs1_i = r1; rs2_i = r2; funct3_i = f3;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    logic [31:0] exp_ins;
    logic        exp_err;
    int          exp_cnt;
    int          exp_errs;
    int          acc;
    int          outs;
    logic        rdy_s;
    logic        seen_stall;

    initial begin
        vecs[0] = '{2'b00, -32'sd1,    5'd5,  5'd6, 5'd0,  3'd0, 32'hFFF30293, 1'b0, 32'hFFF30293};
        vecs[1] = '{2'b10, 32'd8,      5'd31, 5'd2, 5'd10, 3'd2, 32'h00A12423, 1'b0, 32'h00A12423};
        vecs[2] = '{2'b11, -32'sd4,    5'd31, 5'd1, 5'd2,  3'd0, 32'hFE208EE3, 1'b0, 32'hFE208EE3};
        vecs[3] = '{2'b11, 32'd3,      5'd0,  5'd1, 5'd2,  3'd0, 32'h00000013, 1'b1, 32'h00208163};
        vecs[4] = '{2'b01, 32'd2047,   5'd1,  5'd2, 5'd31, 3'd2, 32'h7FF12083, 1'b0, 32'h7FF12083};
        vecs[5] = '{2'b00, 32'd2048,   5'd0,  5'd0, 5'd0,  3'd0, 32'h00000013, 1'b1, 32'h80000013};
        vecs[6] = '{2'b00, -32'sd2048, 5'd0,  5'd0, 5'd0,  3'd0, 32'h80000013, 1'b0, 32'h80000013};
        vecs[7] = '{2'b11, 32'd4094,   5'd0,  5'd0, 5'd0,  3'd0, 32'h7E000FE3, 1'b0, 32'h7E000FE3};
        vecs[8] = '{2'b11, 32'd4096,   5'd0,  5'd0, 5'd0,  3'd0, 32'h00000013, 1'b1, 32'h80000063};
        vecs[9] = '{2'b10, -32'sd2049, 5'd0,  5'd0, 5'd0,  3'd0, 32'h00000013, 1'b1, 32'h7E000FA3};

        set_req(1'b0, 2'b00, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        do_reset();

        // Reset then idle.
        @(negedge clk_i);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_ins", ins_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_count", {16'd0, count_o}, 32'd0);
        check("rst_err_count", {24'd0, err_count_o}, 32'd0);

        // Table: one request at a time, latency and value checked.
        exp_cnt = 0;
        exp_errs = 0;
        for (int i = 0; i < NV; i++) begin
`ifdef IMM_ENC_RANGE_CHECK_EN
            exp_ins = vecs[i].ins_chk;
            exp_err = vecs[i].err_chk;
`else
            exp_ins = vecs[i].ins_raw;
            exp_err = 1'b0;
`endif
            set_req(1'b1, vecs[i].fmt, vecs[i].imm, vecs[i].rd,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].f3);
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready_o}, 32'd1);
            @(negedge clk_i);
            in_valid_i = 1'b0;
            exp_cnt++;
            check($sformatf("v%0d_lat1_valid", i), {31'd0, out_valid_o}, 32'd0);
            @(negedge clk_i);
            check($sformatf("v%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
            check($sformatf("v%0d_ins", i), ins_o, exp_ins);
            check($sformatf("v%0d_err", i), {31'd0, err_o}, {31'd0, exp_err});
            if (exp_err) exp_errs++;
            @(negedge clk_i);
            check($sformatf("v%0d_drained", i), {31'd0, out_valid_o}, 32'd0);
            check($sformatf("v%0d_count", i), {16'd0, count_o}, exp_cnt);
            check($sformatf("v%0d_err_count", i), {24'd0, err_count_o}, exp_errs);
        end

        // Back-to-back stream of 4 with out_ready_i low for 3 cycles.
        do_reset();
        acc = 0;
        outs = 0;
        seen_stall = 1'b0;
        for (int c = 0; c < 30 && outs < 4; c++) begin
            out_ready_i = (c >= 3);
            if (acc < 4)
                set_req(1'b1, 2'b00, acc + 1, acc + 1, 5'd0, 5'd0, 3'd0);
            else
                in_valid_i = 1'b0;
            #1;
            rdy_s = in_ready_o;
            if (acc == 2 && c < 3) begin
                check("bp_stall_in_ready", {31'd0, rdy_s}, 32'd0);
                seen_stall = 1'b1;
            end
            if (out_valid_o) begin
                // Held word must be the next in-order result, also while stalled.
                exp_ins = ((outs + 1) << 20) | ((outs + 1) << 7) | 32'h13;
                check($sformatf("bp_out%0d_c%0d", outs, c), ins_o, exp_ins);
                if (out_ready_i) outs++;
            end
            if (in_valid_i && rdy_s) acc++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        check("bp_stall_seen", {31'd0, seen_stall}, 32'd1);
        check("bp_outputs", outs, 32'd4);
        check("bp_count", {16'd0, count_o}, 32'd4);

        // Fill both stages, then assert reset asynchronously.
        out_ready_i = 1'b0;
        set_req(1'b1, 2'b10, 32'd8, 5'd0, 5'd2, 5'd10, 3'd2);
        repeat (2) @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        check("full_out_valid", {31'd0, out_valid_o}, 32'd1);
        check("full_in_ready", {31'd0, in_ready_o}, 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("arst_ins", ins_o, 32'd0);
        check("arst_err", {31'd0, err_o}, 32'd0);
        check("arst_count", {16'd0, count_o}, 32'd0);
        check("arst_err_count", {24'd0, err_count_o}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("post_rst_no_output", {31'd0, out_valid_o}, 32'd0);
        check("post_rst_count", {16'd0, count_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
